// File: rtl/tych_pkg.sv
// Shared tych types: MAC RX beat, buffered packet beat and
// the ingress write-side state encoding.
package tych_pkg;

    localparam int TYCH_CNT_W = 32;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic         valid;
        logic [5:0]   errors;
    } mac_avlrx_t;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [511:0] data;
    } tych_rx_beat_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_e;

endpackage

// File: rtl/tych_rx_ingress_mem.sv
// Packet buffer: simple dual-port RAM whose read register doubles
// as the ingress output register (held while re is low).
module tych_rx_ingress_mem
    import tych_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tych_rx_beat_t wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output tych_rx_beat_t rdata
);

    tych_rx_beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tych_rx_ingress.sv
// Per-port RX ingress: store-and-forward packet FIFO that commits
// clean packets at EOP and drops errored/overflowing/broken ones.
module tych_rx_ingress
    import tych_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = TYCH_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  mac_avlrx_t       mac_rx,
    output logic [511:0]     out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] drop_err_cnt,
    output logic [CNT_W-1:0] drop_ovf_cnt,
    output logic [CNT_W-1:0] drop_frm_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    wr_state_e     state;
    wr_state_e     state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_tmp;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] base;
    logic [PW-1:0] tmp_nxt;
    logic          full_b;
    logic          take;
    logic          we;
    logic          commit;
    logic          inc_ok;
    logic          inc_err;
    logic          inc_ovf;
    logic          inc_frm;
    logic          load;
    tych_rx_beat_t wr_beat;
    tych_rx_beat_t rd_beat;

    // A SOP always restarts from the last committed packet boundary.
    assign base   = mac_rx.sop ? wr_ptr : wr_tmp;
    assign full_b = (base - rd_ptr) == DEPTH_P;
    assign take   = mac_rx.valid && (mac_rx.sop || state == WR_RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            if (mac_rx.eop) begin
                state_nxt = WR_IDLE;
            end else if (full_b) begin
                state_nxt = WR_DROP;
            end else begin
                state_nxt = WR_RECV;
            end
        end else if (mac_rx.valid && state == WR_DROP && mac_rx.eop) begin
            state_nxt = WR_IDLE;
        end
    end

    always_comb begin
        we      = 1'b0;
        commit  = 1'b0;
        tmp_nxt = wr_tmp;
        inc_ok  = 1'b0;
        inc_err = 1'b0;
        inc_ovf = 1'b0;
        inc_frm = 1'b0;
        if (take) begin
            if (full_b) begin
                tmp_nxt = wr_ptr;
                inc_ovf = mac_rx.eop;
            end else begin
                we      = 1'b1;
                tmp_nxt = base + PW'(1);
                if (mac_rx.eop) begin
                    if (|mac_rx.errors) begin
                        tmp_nxt = wr_ptr;
                        inc_err = 1'b1;
                    end else begin
                        commit = 1'b1;
                        inc_ok = 1'b1;
                    end
                end
            end
            if (mac_rx.sop && state == WR_RECV) begin
                inc_frm = 1'b1;
            end
            if (mac_rx.sop && state == WR_DROP) begin
                inc_ovf = 1'b1;
            end
        end else if (mac_rx.valid) begin
            if (state == WR_IDLE) begin
                inc_frm = 1'b1;
            end else if (mac_rx.eop) begin
                inc_ovf = 1'b1;
            end
        end
    end

    assign load = (rd_ptr != wr_ptr) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            wr_tmp       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            pkt_ok_cnt   <= '0;
            drop_err_cnt <= '0;
            drop_ovf_cnt <= '0;
            drop_frm_cnt <= '0;
        end else begin
            wr_tmp <= tmp_nxt;
            if (commit) begin
                wr_ptr <= tmp_nxt;
            end
            if (load) begin
                rd_ptr    <= rd_ptr + PW'(1);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (inc_ok && !(&pkt_ok_cnt)) begin
                pkt_ok_cnt <= pkt_ok_cnt + CNT_W'(1);
            end
            if (inc_err && !(&drop_err_cnt)) begin
                drop_err_cnt <= drop_err_cnt + CNT_W'(1);
            end
            if (inc_ovf && !(&drop_ovf_cnt)) begin
                drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(1);
            end
            if (inc_frm && !(&drop_frm_cnt)) begin
                drop_frm_cnt <= drop_frm_cnt + CNT_W'(1);
            end
        end
    end

    assign wr_beat.sop  = mac_rx.sop;
    assign wr_beat.eop  = mac_rx.eop;
    assign wr_beat.data = mac_rx.data;

    tych_rx_ingress_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(base[AW-1:0]),
        .wdata(wr_beat),
        .re   (load),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rd_beat)
    );

    assign out_data = rd_beat.data;
    assign out_sop  = rd_beat.sop;
    assign out_eop  = rd_beat.eop;

endmodule

// File: tb/tb_tych_rx_ingress.sv
// Bench for tych_rx_ingress: packet-level queue model checked every
// cycle, plus directed literal expectations per scenario.
module tb_tych_rx_ingress;
    import tych_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    mac_avlrx_t       mac_rx;
    logic [511:0]     out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] pkt_ok_cnt;
    logic [CNT_W-1:0] drop_err_cnt;
    logic [CNT_W-1:0] drop_ovf_cnt;
    logic [CNT_W-1:0] drop_frm_cnt;

    tych_rx_ingress #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mac_rx      (mac_rx),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pkt_ok_cnt  (pkt_ok_cnt),
        .drop_err_cnt(drop_err_cnt),
        .drop_ovf_cnt(drop_ovf_cnt),
        .drop_frm_cnt(drop_frm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] dat(input logic [7:0] d);
        return {64{d}};
    endfunction

    // Model state: committed-but-unloaded beats, current partial packet,
    // output register, counters.
    tych_rx_beat_t fifo_q[$];
    tych_rx_beat_t cur_q[$];
    tych_rx_beat_t m_out;
    logic          m_ov;
    logic          in_pkt;
    logic          dropping;
    logic [31:0]   m_ok, m_err, m_ovf, m_frm;
    logic          hold_chk;
    logic [511:0]  hold_d;
    logic          started = 1'b0;

    function automatic logic [31:0] sat(input logic [31:0] v, input logic i);
        return (i && v != '1) ? v + 32'd1 : v;
    endfunction

    always @(posedge clk) begin : mdl
        int            occ;
        logic          i_ok, i_err, i_ovf, i_frm;
        tych_rx_beat_t b;
        if (rst) begin
            fifo_q.delete();
            cur_q.delete();
            m_out    = '0;
            m_ov     = 1'b0;
            in_pkt   = 1'b0;
            dropping = 1'b0;
            m_ok     = '0;
            m_err    = '0;
            m_ovf    = '0;
            m_frm    = '0;
            hold_chk = 1'b0;
            started  = 1'b1;
        end else begin
            hold_chk = out_valid && !out_ready;
            hold_d   = out_data;
            occ      = fifo_q.size();
            i_ok = 0; i_err = 0; i_ovf = 0; i_frm = 0;
            if (fifo_q.size() > 0 && (!m_ov || out_ready)) begin
                m_ov  = 1'b1;
                m_out = fifo_q.pop_front();
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (mac_rx.valid) begin
                b.sop  = mac_rx.sop;
                b.eop  = mac_rx.eop;
                b.data = mac_rx.data;
                if (mac_rx.sop) begin
                    if (in_pkt) i_frm = 1;
                    if (dropping) i_ovf = 1;
                    cur_q.delete();
                    in_pkt   = 1'b0;
                    dropping = 1'b0;
                end
                if (mac_rx.sop || in_pkt) begin
                    if (occ + cur_q.size() == DEPTH) begin
                        cur_q.delete();
                        in_pkt = 1'b0;
                        if (mac_rx.eop) i_ovf = 1;
                        else dropping = 1'b1;
                    end else begin
                        cur_q.push_back(b);
                        if (mac_rx.eop) begin
                            if (mac_rx.errors != 0) begin
                                i_err = 1;
                            end else begin
                                foreach (cur_q[k]) fifo_q.push_back(cur_q[k]);
                                i_ok = 1;
                            end
                            cur_q.delete();
                            in_pkt = 1'b0;
                        end else begin
                            in_pkt = 1'b1;
                        end
                    end
                end else if (dropping) begin
                    if (mac_rx.eop) begin
                        i_ovf    = 1;
                        dropping = 1'b0;
                    end
                end else begin
                    i_frm = 1;
                end
            end
            m_ok  = sat(m_ok, i_ok);
            m_err = sat(m_err, i_err);
            m_ovf = sat(m_ovf, i_ovf);
            m_frm = sat(m_frm, i_frm);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("out_data", out_data, m_out.data);
                chk("out_sop", out_sop, m_out.sop);
                chk("out_eop", out_eop, m_out.eop);
            end
            chk("pkt_ok_cnt", pkt_ok_cnt, m_ok);
            chk("drop_err_cnt", drop_err_cnt, m_err);
            chk("drop_ovf_cnt", drop_ovf_cnt, m_ovf);
            chk("drop_frm_cnt", drop_frm_cnt, m_frm);
            if (hold_chk) chk("hold_data", out_data, hold_d);
        end
    end

    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            log_q.push_back({out_sop, out_eop, out_data[7:0]});
    end

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, 512'(log_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk(nm, 512'(log_q[i]), 512'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic chk_cnt(input string nm, input int ok, input int er,
                           input int ov, input int fr);
        chk({nm, "_ok"}, pkt_ok_cnt, 512'(ok));
        chk({nm, "_err"}, drop_err_cnt, 512'(er));
        chk({nm, "_ovf"}, drop_ovf_cnt, 512'(ov));
        chk({nm, "_frm"}, drop_frm_cnt, 512'(fr));
    endtask

    task automatic put(input logic s, input logic e, input logic [7:0] d,
                       input logic [5:0] er);
        mac_rx.valid  = 1'b1;
        mac_rx.sop    = s;
        mac_rx.eop    = e;
        mac_rx.data   = dat(d);
        mac_rx.errors = er;
        @(posedge clk);
        #1;
        mac_rx.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        mac_rx.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        mac_rx.valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete();
    endtask

    localparam logic [3:0] RDY_PAT = 4'b1001;

    initial begin
        rst       = 1'b1;
        mac_rx    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_data", out_data, 0);
        chk_cnt("rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // clean 3-beat packet, latency and order
        put(1, 0, 8'hA1, 0);
        put(0, 0, 8'hA2, 0);
        put(0, 1, 8'hA3, 0);
        mac_rx.valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_n2_sop", out_sop, 1);
        chk("lat_n2_data", out_data, dat(8'hA1));
        idle(6);
        exp_q = '{10'h2A1, 10'h0A2, 10'h1A3};
        chk_log("t1_log");
        chk_cnt("t1", 1, 0, 0, 0);

        // single beat, then errored packet
        do_reset();
        put(1, 1, 8'hB1, 0);
        put(1, 0, 8'hC1, 0);
        put(0, 1, 8'hC2, 6'h01);
        idle(6);
        exp_q = '{10'h3B1};
        chk_log("t2_log");
        chk_cnt("t2", 1, 1, 0, 0);
        chk("t2_empty", out_valid, 0);

        // overflow with DEPTH=4, then oversize packet
        do_reset();
        out_ready = 1'b0;
        put(1, 0, 8'hD1, 0);
        put(0, 0, 8'hD2, 0);
        put(0, 1, 8'hD3, 0);
        put(1, 0, 8'hE1, 0);
        put(0, 0, 8'hE2, 0);
        put(0, 1, 8'hE3, 0);
        idle(2);
        chk_cnt("t3a", 1, 0, 1, 0);
        out_ready = 1'b1;
        idle(8);
        exp_q = '{10'h2D1, 10'h0D2, 10'h1D3};
        chk_log("t3_log");
        put(1, 0, 8'hF1, 0);
        for (int i = 2; i <= 4; i++) put(0, 0, 8'(8'hF0 + i), 0);
        put(0, 1, 8'hF5, 0);
        idle(6);
        chk_cnt("t3b", 1, 0, 2, 0);
        chk("t3_nolog", 512'(log_q.size()), 512'(3));

        // framing: orphan, then abort by new SOP
        do_reset();
        put(0, 0, 8'h61, 0);
        idle(3);
        chk_cnt("t4a", 0, 0, 0, 1);
        chk("t4_orphan_out", out_valid, 0);
        put(1, 0, 8'h71, 0);
        put(0, 0, 8'h72, 0);
        put(1, 0, 8'h81, 0);
        put(0, 1, 8'h82, 0);
        idle(6);
        exp_q = '{10'h281, 10'h182};
        chk_log("t4_log");
        chk_cnt("t4b", 1, 0, 0, 2);

        // backpressure: ready 1,0,0,1,...
        do_reset();
        out_ready = 1'b0;
        put(1, 0, 8'h91, 0);
        put(0, 0, 8'h92, 0);
        put(0, 0, 8'h93, 0);
        put(0, 1, 8'h94, 0);
        for (int i = 0; i < 16; i++) begin
            out_ready = RDY_PAT[3 - (i % 4)];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(4);
        exp_q = '{10'h291, 10'h092, 10'h093, 10'h194};
        chk_log("t5_log");
        chk_cnt("t5", 1, 0, 0, 0);

        // reset mid-packet with a committed packet buffered
        do_reset();
        out_ready = 1'b0;
        put(1, 0, 8'h31, 0);
        put(0, 1, 8'h32, 0);
        idle(3);
        put(1, 0, 8'h41, 0);
        put(0, 0, 8'h42, 0);
        chk("t6_pre_ok", pkt_ok_cnt, 1);
        do_reset();
        @(negedge clk);
        chk_cnt("t6_rst", 0, 0, 0, 0);
        chk("t6_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        put(1, 0, 8'h51, 0);
        put(0, 1, 8'h52, 0);
        idle(6);
        exp_q = '{10'h251, 10'h152};
        chk_log("t6_log");
        chk_cnt("t6", 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
